cac_fill_seq: RTL and testbench
===============================

# cac_fill_seq

Cache data-RAM write sequencer for the cache data slices. Sequences the four-word quadword fill from memory after a miss and single-word CPU store hits into the selected way, driving the shared cache address, way-select, write-strobe, write-data and parity lines that fan out to every cache data slice. It sits between the cache directory/miss logic and the memory port, and owns the data-RAM write path.

## Interface
- NWAYS, 4, number of cache ways; sets the width of the one-hot select.
- WR_CYCLES, 1, number of cycles cache_wr_l is held low per word (1..4).
- TIMEOUT, 255, number of WAIT cycles with no memory data before a fill aborts (8-bit counter).

- clk_h  in  1  system clock; all state changes on the rising edge.
- reset_l  in  1  asynchronous active-low reset.
- fill_req_h  in  1  start a quadword fill; sampled in IDLE only.
- fill_way_h  in  2  way to fill.
- fill_line_h  in  7  line index, cache address bits 27-33.
- fill_first_h  in  2  first word requested, address bits 34-35.
- fill_busy_h  out  1  high from fill acceptance until DONE or abort.
- fill_done_h  out  1  one-cycle pulse after the 4th word is written.
- fill_err_h  out  1  one-cycle pulse on timeout or protocol error.
- mem_rd_req_h  out  1  memory read request; held until mem_rd_ack_h.
- mem_rd_ack_h  in  1  memory accepted the request.
- mem_data_vld_h  in  1  one memory word is valid on mem_data_h.
- mem_data_h  in  36  memory read word.
- cpu_wr_req_h  in  1  CPU store hit request.
- cpu_wr_way_h  in  2  way for the store.
- cpu_wr_adr_h  in  9  address bits 27-35 for the store.
- cpu_wr_data_h  in  36  store data.
- cpu_wr_ack_h  out  1  one-cycle pulse when the store is complete.
- cache_adr_h  out  9  cache address bits 27-35 to the data slices.
- csh_sel_l  out  NWAYS  active-low one-hot way select.
- cache_wr_l  out  1  active-low write strobe.
- mem_to_cache_h  out  36  write data to the slices.
- csh_par_bit_in_h  out  1  odd parity of mem_to_cache_h.

## Operation
- States: IDLE, CPUWR, REQ, WAIT, SETUP, STROBE, HOLD, DONE.
- IDLE has the following transitions:
  - On cpu_wr_req_h, go to SETUP with the CPU address, way and data latched. The store path skips REQ and WAIT.
  - Otherwise, on fill_req_h, latch the way, line and first word, clear the word counter, and go to REQ.
  - If both requests are present, the CPU store wins. fill_req_h must remain asserted and is taken when the FSM returns to IDLE.
- REQ: mem_rd_req_h is high. On mem_rd_ack_h, go to WAIT and clear the timeout counter.
- WAIT has the following transitions:
  - On mem_data_vld_h, latch mem_data_h and go to SETUP.
  - If the counter reaches TIMEOUT, pulse fill_err_h, drop fill_busy_h and return to IDLE. No write is performed for the missing word.
- SETUP: address, select and data are driven and cache_wr_l is high. Go to STROBE.
- STROBE: cache_wr_l is low for WR_CYCLES cycles. Go to HOLD.
- HOLD: cache_wr_l is high and address, select and data remain stable. Then:
  - For a CPU store, pulse cpu_wr_ack_h in HOLD and go to IDLE.
  - For a fill, increment the word counter. If 4 words have been written, go to DONE; otherwise go to WAIT and clear the timeout counter.
- DONE: pulse fill_done_h, drop fill_busy_h, go to IDLE.
- Fill word order wraps: the address for the word at count n is {line, (first+n) mod 4}. For example, first=2 gives the order 2,3,0,1. Memory delivers words in this order.
- mem_data_vld_h outside WAIT during a fill is a protocol error: pulse fill_err_h, discard the word, and continue the sequence.
- csh_par_bit_in_h = ~^mem_to_cache_h, so the 37-bit word has an odd number of ones.
- Outside SETUP, STROBE and HOLD, csh_sel_l is all ones and cache_wr_l is 1.

## Timing
- Reset, asynchronous and immediate, drives the following values:
  - state IDLE and counters 0;
  - csh_sel_l all ones, cache_wr_l 1;
  - cache_adr_h 0, mem_to_cache_h 0, csh_par_bit_in_h 1;
  - mem_rd_req_h 0, fill_busy_h 0, fill_done_h 0, fill_err_h 0, cpu_wr_ack_h 0.
- Reset mid-write aborts the strobe at once, with no completion pulse.
- All outputs are registered.
- CPU store: request seen at edge 0, then SETUP in cycle 1, STROBE in cycles 2..1+WR_CYCLES, and HOLD with cpu_wr_ack_h in cycle 2+WR_CYCLES. Total latency is WR_CYCLES+2 cycles.
- Fill with WR_CYCLES=1 and zero memory wait: request seen at edge 0, REQ in cycle 1, and 1 cycle after ack the FSM is in WAIT. Each word costs data, then SETUP, STROBE and HOLD, giving a minimum word spacing of WR_CYCLES+3 cycles.
- fill_busy_h rises in the cycle after acceptance and falls with DONE or abort.
- Address, select and data change only on entry to SETUP, never while cache_wr_l is low.

## Test plan
- Reset mid-STROBE of a fill -> next cycle csh_sel_l=4'hF and cache_wr_l=1; no fill_done_h; fill_busy_h=0.
- CPU store to way 1, adr 9'h1A5, data 36'h0_0000_0001, WR_CYCLES=1 -> csh_sel_l=4'b1101, cache_adr_h=9'h1A5, cache_wr_l low for exactly 1 cycle, csh_par_bit_in_h=0, cpu_wr_ack_h in the 3rd cycle after the request.
- Fill to way 3, line 7'h15, first=2, with words 36'h111111111, 36'h222222222, 36'h333333333, 36'h444444444 -> four strobes at adr 9'h056, 9'h057, 9'h054, 9'h055, with sel 4'b0111 and matching data and parity, then a single fill_done_h.
- Simultaneous fill_req_h and cpu_wr_req_h in IDLE -> CPU store completes first, and the mem_rd_req_h rise follows cpu_wr_ack_h.
- Fill acked but no data for 255 cycles -> fill_err_h pulse, fill_busy_h falls, no cache_wr_l strobe.
- mem_data_vld_h asserted during STROBE -> fill_err_h pulse, the word is not written, and the sequence still finishes its remaining writes.

Source files
------------

// File: rtl/cac_fill_seq.sv
// Cache data-RAM write sequencer.
// Handles two kinds of write: a four-word quadword fill from memory after a
// miss, and a single-word CPU store hit. It drives the shared address,
// way-select, strobe, data and parity lines that go to every data slice.
// Every output comes straight from a flop.
module cac_fill_seq #(
    parameter int NWAYS     = 4,
    parameter int WR_CYCLES = 1,
    parameter int TIMEOUT   = 255
) (
    input  logic             clk_h,
    input  logic             reset_l,
    input  logic             fill_req_h,
    input  logic [1:0]       fill_way_h,
    input  logic [6:0]       fill_line_h,
    input  logic [1:0]       fill_first_h,
    output logic             fill_busy_h,
    output logic             fill_done_h,
    output logic             fill_err_h,
    output logic             mem_rd_req_h,
    input  logic             mem_rd_ack_h,
    input  logic             mem_data_vld_h,
    input  logic [35:0]      mem_data_h,
    input  logic             cpu_wr_req_h,
    input  logic [1:0]       cpu_wr_way_h,
    input  logic [8:0]       cpu_wr_adr_h,
    input  logic [35:0]      cpu_wr_data_h,
    output logic             cpu_wr_ack_h,
    output logic [8:0]       cache_adr_h,
    output logic [NWAYS-1:0] csh_sel_l,
    output logic             cache_wr_l,
    output logic [35:0]      mem_to_cache_h,
    output logic             csh_par_bit_in_h
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CPUWR  = 3'd1,
        S_REQ    = 3'd2,
        S_WAIT   = 3'd3,
        S_SETUP  = 3'd4,
        S_STROBE = 3'd5,
        S_HOLD   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    localparam logic [1:0]       STB_LAST = 2'(WR_CYCLES - 1);
    localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [NWAYS-1:0] SEL_NONE = {NWAYS{1'b1}};

    // The 37-bit word {data, parity} must contain an odd number of ones.
    function automatic logic odd_par(input logic [35:0] d);
        return ~^d;
    endfunction

    // Convert a way number to the active-low one-hot slice select.
    function automatic logic [NWAYS-1:0] way_sel_n(input logic [1:0] way);
        return ~(NWAYS'(1'b1) << way);
    endfunction

    state_t           state_q;
    logic             is_fill_q;
    logic [1:0]       fill_way_q;
    logic [6:0]       fill_line_q;
    logic [1:0]       fill_first_q;
    logic [1:0]       word_cnt_q;
    logic [7:0]       tmo_cnt_q;
    logic [1:0]       stb_cnt_q;
    logic [8:0]       cache_adr_q;
    logic [NWAYS-1:0] csh_sel_q;
    logic             cache_wr_q;
    logic [35:0]      wr_data_q;
    logic             par_q;
    logic             mem_rd_req_q;
    logic             fill_busy_q;
    logic             fill_done_q;
    logic             fill_err_q;
    logic             cpu_wr_ack_q;

    // Low two address bits of the current fill word. The 2-bit add gives the
    // wrap-around word order.
    logic [1:0] word_lo_s;
    assign word_lo_s = fill_first_q + word_cnt_q;

    // Sequencer: state, counters and every registered output.
    always_ff @(posedge clk_h or negedge reset_l) begin
        if (!reset_l) begin
            state_q      <= S_IDLE;
            is_fill_q    <= 1'b0;
            fill_way_q   <= 2'd0;
            fill_line_q  <= 7'd0;
            fill_first_q <= 2'd0;
            word_cnt_q   <= 2'd0;
            tmo_cnt_q    <= 8'd0;
            stb_cnt_q    <= 2'd0;
            cache_adr_q  <= 9'd0;
            csh_sel_q    <= SEL_NONE;
            cache_wr_q   <= 1'b1;
            wr_data_q    <= 36'd0;
            par_q        <= 1'b1;
            mem_rd_req_q <= 1'b0;
            fill_busy_q  <= 1'b0;
            fill_done_q  <= 1'b0;
            fill_err_q   <= 1'b0;
            cpu_wr_ack_q <= 1'b0;
        end else begin
            fill_done_q  <= 1'b0;
            fill_err_q   <= 1'b0;
            cpu_wr_ack_q <= 1'b0;

            // A memory word that arrives while the fill is not waiting for
            // one is discarded and flagged.
            if (mem_data_vld_h && fill_busy_q && (state_q != S_WAIT)) begin
                fill_err_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (cpu_wr_req_h) begin
                        is_fill_q   <= 1'b0;
                        cache_adr_q <= cpu_wr_adr_h;
                        csh_sel_q   <= way_sel_n(cpu_wr_way_h);
                        wr_data_q   <= cpu_wr_data_h;
                        par_q       <= odd_par(cpu_wr_data_h);
                        state_q     <= S_SETUP;
                    end else if (fill_req_h) begin
                        is_fill_q    <= 1'b1;
                        fill_way_q   <= fill_way_h;
                        fill_line_q  <= fill_line_h;
                        fill_first_q <= fill_first_h;
                        word_cnt_q   <= 2'd0;
                        mem_rd_req_q <= 1'b1;
                        fill_busy_q  <= 1'b1;
                        state_q      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_rd_ack_h) begin
                        mem_rd_req_q <= 1'b0;
                        tmo_cnt_q    <= 8'd0;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_data_vld_h) begin
                        cache_adr_q <= {fill_line_q, word_lo_s};
                        csh_sel_q   <= way_sel_n(fill_way_q);
                        wr_data_q   <= mem_data_h;
                        par_q       <= odd_par(mem_data_h);
                        state_q     <= S_SETUP;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        fill_err_q  <= 1'b1;
                        fill_busy_q <= 1'b0;
                        is_fill_q   <= 1'b0;
                        state_q     <= S_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                S_SETUP: begin
                    cache_wr_q <= 1'b0;
                    stb_cnt_q  <= 2'd0;
                    state_q    <= S_STROBE;
                end
                S_STROBE: begin
                    if (stb_cnt_q == STB_LAST) begin
                        cache_wr_q   <= 1'b1;
                        cpu_wr_ack_q <= ~is_fill_q;
                        state_q      <= S_HOLD;
                    end else begin
                        stb_cnt_q <= stb_cnt_q + 2'd1;
                    end
                end
                S_HOLD: begin
                    csh_sel_q <= SEL_NONE;
                    if (!is_fill_q) begin
                        state_q <= S_IDLE;
                    end else if (word_cnt_q == 2'd3) begin
                        word_cnt_q  <= 2'd0;
                        fill_done_q <= 1'b1;
                        fill_busy_q <= 1'b0;
                        state_q     <= S_DONE;
                    end else begin
                        word_cnt_q <= word_cnt_q + 2'd1;
                        tmo_cnt_q  <= 8'd0;
                        state_q    <= S_WAIT;
                    end
                end
                S_DONE: begin
                    is_fill_q <= 1'b0;
                    state_q   <= S_IDLE;
                end
                S_CPUWR: begin
                    state_q <= S_SETUP;
                end
                default: begin
                    csh_sel_q   <= SEL_NONE;
                    cache_wr_q  <= 1'b1;
                    fill_busy_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign fill_busy_h      = fill_busy_q;
    assign fill_done_h      = fill_done_q;
    assign fill_err_h       = fill_err_q;
    assign mem_rd_req_h     = mem_rd_req_q;
    assign cpu_wr_ack_h     = cpu_wr_ack_q;
    assign cache_adr_h      = cache_adr_q;
    assign csh_sel_l        = csh_sel_q;
    assign cache_wr_l       = cache_wr_q;
    assign mem_to_cache_h   = wr_data_q;
    assign csh_par_bit_in_h = par_q;

endmodule

// File: tb/tb_cac_fill_seq.sv
// Directed self-checking bench for cac_fill_seq (NWAYS=4, WR_CYCLES=1).
module tb_cac_fill_seq;

    logic        clk_h = 1'b0;
    logic        reset_l = 1'b0;
    logic        fill_req_h = 1'b0;
    logic [1:0]  fill_way_h = 2'd0;
    logic [6:0]  fill_line_h = 7'd0;
    logic [1:0]  fill_first_h = 2'd0;
    logic        fill_busy_h, fill_done_h, fill_err_h, mem_rd_req_h;
    logic        mem_rd_ack_h = 1'b0;
    logic        mem_data_vld_h = 1'b0;
    logic [35:0] mem_data_h = 36'd0;
    logic        cpu_wr_req_h = 1'b0;
    logic [1:0]  cpu_wr_way_h = 2'd0;
    logic [8:0]  cpu_wr_adr_h = 9'd0;
    logic [35:0] cpu_wr_data_h = 36'd0;
    logic        cpu_wr_ack_h;
    logic [8:0]  cache_adr_h;
    logic [3:0]  csh_sel_l;
    logic        cache_wr_l;
    logic [35:0] mem_to_cache_h;
    logic        csh_par_bit_in_h;

    cac_fill_seq #(.NWAYS(4), .WR_CYCLES(1), .TIMEOUT(255)) dut (
        .clk_h(clk_h), .reset_l(reset_l),
        .fill_req_h(fill_req_h), .fill_way_h(fill_way_h),
        .fill_line_h(fill_line_h), .fill_first_h(fill_first_h),
        .fill_busy_h(fill_busy_h), .fill_done_h(fill_done_h), .fill_err_h(fill_err_h),
        .mem_rd_req_h(mem_rd_req_h), .mem_rd_ack_h(mem_rd_ack_h),
        .mem_data_vld_h(mem_data_vld_h), .mem_data_h(mem_data_h),
        .cpu_wr_req_h(cpu_wr_req_h), .cpu_wr_way_h(cpu_wr_way_h),
        .cpu_wr_adr_h(cpu_wr_adr_h), .cpu_wr_data_h(cpu_wr_data_h),
        .cpu_wr_ack_h(cpu_wr_ack_h), .cache_adr_h(cache_adr_h),
        .csh_sel_l(csh_sel_l), .cache_wr_l(cache_wr_l),
        .mem_to_cache_h(mem_to_cache_h), .csh_par_bit_in_h(csh_par_bit_in_h)
    );

    // Free-running 10 ns clock.
    always #5 clk_h = ~clk_h;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Record of every write strobe seen on the slice bus.
    typedef struct packed {
        logic [8:0]  adr;
        logic [3:0]  sel;
        logic [35:0] data;
        logic        par;
    } stb_t;
    stb_t stbs[$];
    int   n_low = 0, n_done = 0, n_err = 0, n_ack = 0, n_unstable = 0;
    logic prev_wr = 1'b1;
    stb_t last_v;

    // Bus monitor sampled on the falling edge, away from the active edge.
    always @(negedge clk_h) begin
        if (reset_l === 1'b1 && cache_wr_l === 1'b0) begin
            n_low++;
            if (prev_wr === 1'b1) begin
                last_v = {cache_adr_h, csh_sel_l, mem_to_cache_h, csh_par_bit_in_h};
                stbs.push_back(last_v);
            end else if ({cache_adr_h, csh_sel_l, mem_to_cache_h, csh_par_bit_in_h} !== last_v) begin
                n_unstable++;
            end
        end
        if (fill_done_h === 1'b1) n_done++;
        if (fill_err_h === 1'b1) n_err++;
        if (cpu_wr_ack_h === 1'b1) n_ack++;
        prev_wr = cache_wr_l;
    end

    task automatic tick();
        @(posedge clk_h);
        #1;
    endtask

    task automatic wait_wr(input logic lvl, input string tag);
        int n = 0;
        while (cache_wr_l !== lvl && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, cache_wr_l, lvl);
    endtask

    task automatic wait_rd_req();
        int n = 0;
        while (mem_rd_req_h !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check_eq("mem_rd_req_rise", mem_rd_req_h, 1'b1);
    endtask

    // Memory side of a fill: ack the request, then deliver four words. A stray
    // word is pushed during the strobe of word stray_idx (use -1 for none).
    task automatic mem_serve(input logic [143:0] words, input int stray_idx);
        wait_rd_req();
        mem_rd_ack_h = 1'b1;
        tick();
        mem_rd_ack_h = 1'b0;
        check_eq("rd_req_drop", mem_rd_req_h, 1'b0);
        check_eq("busy_in_fill", fill_busy_h, 1'b1);
        for (int i = 0; i < 4; i++) begin
            mem_data_h     = words[i*36 +: 36];
            mem_data_vld_h = 1'b1;
            tick();
            mem_data_vld_h = 1'b0;
            wait_wr(1'b0, "strobe_low");
            if (i == stray_idx) begin
                mem_data_h     = 36'hBADBADBAD;
                mem_data_vld_h = 1'b1;
                tick();
                mem_data_vld_h = 1'b0;
                check_eq("stray_err_pulse", fill_err_h, 1'b1);
            end
            wait_wr(1'b1, "strobe_high");
            tick();
        end
        check_eq("fill_done_pulse", fill_done_h, 1'b1);
        check_eq("busy_drop_done", fill_busy_h, 1'b0);
        tick();
        check_eq("fill_done_clear", fill_done_h, 1'b0);
    endtask

    task automatic check_strobes(input int base, input logic [3:0] sel,
                                 input logic [35:0] adrs, input logic [143:0] words,
                                 input logic [3:0] pars);
        check_eq("fill_strobe_count", stbs.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("w%0d_adr", i), stbs[base+i].adr, adrs[i*9 +: 9]);
            check_eq($sformatf("w%0d_sel", i), stbs[base+i].sel, sel);
            check_eq($sformatf("w%0d_data", i), stbs[base+i].data, words[i*36 +: 36]);
            check_eq($sformatf("w%0d_par", i), stbs[base+i].par, pars[i]);
        end
    endtask

    // Hang guard.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, done0, err0, ack0, low0, n;
        logic rd_early;

        // Reset state.
        repeat (3) tick();
        check_eq("rst_sel", csh_sel_l, 4'hF);
        check_eq("rst_wr", cache_wr_l, 1'b1);
        check_eq("rst_adr", cache_adr_h, 9'h000);
        check_eq("rst_data", mem_to_cache_h, 36'h0);
        check_eq("rst_par", csh_par_bit_in_h, 1'b1);
        check_eq("rst_rdreq", mem_rd_req_h, 1'b0);
        check_eq("rst_busy", fill_busy_h, 1'b0);
        check_eq("rst_done", fill_done_h, 1'b0);
        check_eq("rst_err", fill_err_h, 1'b0);
        check_eq("rst_ack", cpu_wr_ack_h, 1'b0);
        reset_l = 1'b1;
        repeat (2) tick();

        // CPU store: way 1, adr 1A5, data 1.
        low0 = n_low; ack0 = n_ack;
        cpu_wr_req_h = 1'b1; cpu_wr_way_h = 2'd1;
        cpu_wr_adr_h = 9'h1A5; cpu_wr_data_h = 36'h0_0000_0001;
        tick();
        cpu_wr_req_h = 1'b0;
        check_eq("cpu_setup_adr", cache_adr_h, 9'h1A5);
        check_eq("cpu_setup_sel", csh_sel_l, 4'b1101);
        check_eq("cpu_setup_wr", cache_wr_l, 1'b1);
        check_eq("cpu_data", mem_to_cache_h, 36'h0_0000_0001);
        check_eq("cpu_par", csh_par_bit_in_h, 1'b0);
        tick();
        check_eq("cpu_strobe", cache_wr_l, 1'b0);
        check_eq("cpu_ack_early", cpu_wr_ack_h, 1'b0);
        tick();
        check_eq("cpu_hold_wr", cache_wr_l, 1'b1);
        check_eq("cpu_ack", cpu_wr_ack_h, 1'b1);
        check_eq("cpu_hold_adr", cache_adr_h, 9'h1A5);
        tick();
        check_eq("cpu_ack_clear", cpu_wr_ack_h, 1'b0);
        check_eq("cpu_idle_sel", csh_sel_l, 4'hF);
        check_eq("cpu_low_cycles", n_low - low0, 1);
        check_eq("cpu_ack_count", n_ack - ack0, 1);

        // Fill way 3, line 15, first word 2.
        base = stbs.size(); done0 = n_done;
        fill_req_h = 1'b1; fill_way_h = 2'd3; fill_line_h = 7'h15; fill_first_h = 2'd2;
        tick();
        fill_req_h = 1'b0;
        check_eq("fill_busy_rise", fill_busy_h, 1'b1);
        mem_serve({36'h444444444, 36'h333333333, 36'h222222222, 36'h111111111}, -1);
        check_strobes(base, 4'b0111, {9'h055, 9'h054, 9'h057, 9'h056},
                      {36'h444444444, 36'h333333333, 36'h222222222, 36'h111111111},
                      4'b0100);
        check_eq("fill_done_count", n_done - done0, 1);

        // Simultaneous requests: store first, then fill with a stray word.
        base = stbs.size(); err0 = n_err; done0 = n_done;
        cpu_wr_req_h = 1'b1; cpu_wr_way_h = 2'd0;
        cpu_wr_adr_h = 9'h0FF; cpu_wr_data_h = 36'h0_0000_0003;
        fill_req_h = 1'b1; fill_way_h = 2'd2; fill_line_h = 7'h00; fill_first_h = 2'd3;
        tick();
        cpu_wr_req_h = 1'b0;
        n = 0; rd_early = 1'b0;
        while (cpu_wr_ack_h !== 1'b1 && n < 20) begin
            if (mem_rd_req_h === 1'b1) rd_early = 1'b1;
            tick();
            n++;
        end
        check_eq("both_cpu_ack", cpu_wr_ack_h, 1'b1);
        check_eq("both_ack_latency", n, 2);
        check_eq("both_rd_before_ack", rd_early | mem_rd_req_h, 1'b0);
        tick();
        check_eq("both_rd_in_idle", mem_rd_req_h, 1'b0);
        tick();
        check_eq("both_rd_rise", mem_rd_req_h, 1'b1);
        fill_req_h = 1'b0;
        check_eq("both_cpu_adr", stbs[base].adr, 9'h0FF);
        check_eq("both_cpu_sel", stbs[base].sel, 4'b1110);
        check_eq("both_cpu_par", stbs[base].par, 1'b1);
        mem_serve({36'h123456789, 36'h800000001, 36'hFFFFFFFFF, 36'h000000000}, 1);
        check_strobes(base + 1, 4'b1011, {9'h002, 9'h001, 9'h000, 9'h003},
                      {36'h123456789, 36'h800000001, 36'hFFFFFFFFF, 36'h000000000},
                      4'b0111);
        check_eq("stray_err_count", n_err - err0, 1);
        check_eq("stray_done_count", n_done - done0, 1);

        // Timeout: acked but no data.
        low0 = n_low; err0 = n_err;
        fill_req_h = 1'b1; fill_way_h = 2'd1; fill_line_h = 7'h2A; fill_first_h = 2'd0;
        tick();
        fill_req_h = 1'b0;
        wait_rd_req();
        mem_rd_ack_h = 1'b1;
        tick();
        mem_rd_ack_h = 1'b0;
        n = 0;
        while (fill_err_h !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
        check_eq("tmo_err", fill_err_h, 1'b1);
        check_eq("tmo_cycles", n, 255);
        check_eq("tmo_busy", fill_busy_h, 1'b0);
        tick();
        check_eq("tmo_err_clear", fill_err_h, 1'b0);
        check_eq("tmo_no_strobe", n_low - low0, 0);
        check_eq("tmo_err_count", n_err - err0, 1);

        // Reset in the middle of a fill strobe.
        done0 = n_done;
        fill_req_h = 1'b1; fill_way_h = 2'd0; fill_line_h = 7'h01; fill_first_h = 2'd1;
        tick();
        fill_req_h = 1'b0;
        wait_rd_req();
        mem_rd_ack_h = 1'b1;
        tick();
        mem_rd_ack_h = 1'b0;
        mem_data_h = 36'h0A5A5A5A5; mem_data_vld_h = 1'b1;
        tick();
        mem_data_vld_h = 1'b0;
        wait_wr(1'b0, "rst_strobe_low");
        #2;
        reset_l = 1'b0;
        #1;
        check_eq("midrst_sel", csh_sel_l, 4'hF);
        check_eq("midrst_wr", cache_wr_l, 1'b1);
        check_eq("midrst_busy", fill_busy_h, 1'b0);
        repeat (2) tick();
        reset_l = 1'b1;
        repeat (6) tick();
        check_eq("midrst_no_done", n_done - done0, 0);
        check_eq("midrst_idle_wr", cache_wr_l, 1'b1);
        check_eq("midrst_idle_rd", mem_rd_req_h, 1'b0);
        check_eq("bus_stable_in_strobe", n_unstable, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
